debounce_pulse: RTL and testbench

- Conditioning stage directly upstream of the D flip-flop lab block.
- Takes a raw, asynchronous, bouncy push-button/switch input and synchronises it to clk.
- Filters bounce with a consecutive-sample counter FSM.
- Outputs a clean level (drives the flip-flop D input), single-cycle rise/fall strobes and a wrapping press counter.

---
 rtl/debounce_pulse.sv | 160 ++++++++++++++++
 tb/tb_debounce_pulse.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Button conditioner: synchroniser, consecutive-sample debounce FSM, edge strobes and press counter.
// Define DEBOUNCE_LONG_PRESS_EN to build the long-hold strobe; otherwise long_press is tied low.
module debounce_pulse #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16,
   parameter int PCOUNT_W        = 8,
   parameter int LONG_CYCLES     = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                btn_in,
   output logic                btn_level,
   output logic                rise_pulse,
   output logic                fall_pulse,
   output logic [PCOUNT_W-1:0] press_count,
   output logic                long_press
);

   localparam logic [1:0] S_LOW    = 2'd0;
   localparam logic [1:0] S_WAIT_H = 2'd1;
   localparam logic [1:0] S_HIGH   = 2'd2;
   localparam logic [1:0] S_WAIT_L = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync_out;
   logic [1:0]             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic [PCOUNT_W-1:0]    r_pcount;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   // The count tracks how many consecutive samples have disagreed with the settled level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_LOW;
         r_cnt    <= '0;
         r_level  <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_pcount <= '0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            S_LOW: begin
               if (w_sync_out) begin
                  r_state <= S_WAIT_H;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_cnt <= '0;
               end
            end
            S_WAIT_H: begin
               if (!w_sync_out) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state  <= S_HIGH;
                  r_cnt    <= '0;
                  r_level  <= 1'b1;
                  r_rise   <= 1'b1;
                  r_pcount <= r_pcount + PCOUNT_W'(1);
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!w_sync_out) begin
                  r_state <= S_WAIT_L;
                  r_cnt   <= CNT_ONE;
               end else begin
                  r_cnt <= '0;
               end
            end
            S_WAIT_L: begin
               if (w_sync_out) begin
                  r_state <= S_HIGH;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
                  r_level <= 1'b0;
                  r_fall  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= S_LOW;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign btn_level   = r_level;
   assign rise_pulse  = r_rise;
   assign fall_pulse  = r_fall;
   assign press_count = r_pcount;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int              HOLD_W    = $clog2(LONG_CYCLES) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

   logic              w_press_accept;
   logic              w_stay_high;
   logic [HOLD_W-1:0] r_hold;
   logic              r_lp_done;
   logic              r_long;

   assign w_press_accept = (r_state == S_WAIT_H) && w_sync_out && (r_cnt == CNT_LAST);
   assign w_stay_high    = (r_state == S_HIGH) && w_sync_out;

   // r_lp_done is only cleared by a fresh debounced press, so a bounce back into S_HIGH cannot re-fire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold    <= '0;
         r_lp_done <= 1'b0;
         r_long    <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (w_press_accept) begin
            r_hold    <= '0;
            r_lp_done <= 1'b0;
         end else if (w_stay_high) begin
            if (r_hold != HOLD_LAST) begin
               r_hold <= r_hold + HOLD_W'(1);
            end
            if ((r_hold == HOLD_PRE) && !r_lp_done) begin
               r_long    <= 1'b1;
               r_lp_done <= 1'b1;
            end
         end else begin
            r_hold <= '0;
         end
      end
   end

   assign long_press = r_long;
`else
   assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: stimulus segments push expected strobes, a negedge monitor pops them.
module tb_debounce_pulse;

   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int CNT_W           = 16;
   localparam int PCOUNT_W        = 8;
   localparam int LONG_CYCLES     = 16;
   localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES - 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                btn_in;
   logic                btn_level;
   logic                rise_pulse;
   logic                fall_pulse;
   logic [PCOUNT_W-1:0] press_count;
   logic                long_press;

   typedef struct {
      int                  edge_no;
      bit                  rise;
      logic [PCOUNT_W-1:0] cnt;
   } ev_t;

   ev_t                 q[$];
   int                  n_chk = 0;
   int                  n_err = 0;
   int                  edge_n = 0;
   int                  rise_seen = 0;
   int                  lp_cnt = 0;
   int                  lp_edge = 0;
   int                  last_rise_edge = 0;
   bit                  model_level = 1'b0;
   logic [PCOUNT_W-1:0] exp_count = '0;

   debounce_pulse #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .PCOUNT_W       (PCOUNT_W),
      .LONG_CYCLES    (LONG_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in),
      .btn_level  (btn_level),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .press_count(press_count),
      .long_press (long_press)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_n);
      end
   endtask

   // Drive one level for n cycles; a differing level held for DEBOUNCE_CYCLES or more must be accepted.
   task automatic seg(input bit v, input int n);
      ev_t e;
      btn_in = v;
      if ((v != model_level) && (n >= DEBOUNCE_CYCLES)) begin
         model_level = v;
         if (v) exp_count = exp_count + 1'b1;
         e.edge_no = edge_n + 1 + LAT;
         e.rise    = v;
         e.cnt     = exp_count;
         q.push_back(e);
      end
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      #2 rst = 1'b1;
      btn_in = 1'b0;
      #1;
      chk("rst_level", btn_level, 0);
      chk("rst_rise", rise_pulse, 0);
      chk("rst_fall", fall_pulse, 0);
      chk("rst_count", press_count, 0);
      chk("rst_long", long_press, 0);
      q.delete();
      model_level = 1'b0;
      exp_count   = '0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         while ((q.size() > 0) && (q[0].edge_no < edge_n)) begin
            chk("missed_strobe", edge_n, q[0].edge_no);
            void'(q.pop_front());
         end
         chk("strobe_exclusive", rise_pulse & fall_pulse, 0);
         if (rise_pulse) begin
            rise_seen++;
            last_rise_edge = edge_n;
         end
         if (long_press) begin
            lp_cnt++;
            lp_edge = edge_n;
         end
         if (rise_pulse || fall_pulse) begin
            if (q.size() == 0) begin
               chk("strobe_expected", q.size(), 1);
            end else begin
               e = q.pop_front();
               chk("strobe_edge", edge_n, e.edge_no);
               chk("rise_pulse", rise_pulse, e.rise);
               chk("fall_pulse", fall_pulse, !e.rise);
               chk("level", btn_level, e.rise);
               chk("press_count", press_count, e.cnt);
            end
         end
      end
   end

   initial begin
      int lp0;
      rst    = 1'b0;
      btn_in = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("init_level", btn_level, 0);
      chk("init_rise", rise_pulse, 0);
      chk("init_fall", fall_pulse, 0);
      chk("init_count", press_count, 0);
      chk("init_long", long_press, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      // btn_in already high at release: first press counted from the release edge
      seg(1'b1, 15);
      seg(1'b0, 10);
      seg(1'b1, 10);
      seg(1'b0, 10);
      // bounce and short glitch rejected
      seg(1'b1, 2); seg(1'b0, 2); seg(1'b1, 2); seg(1'b0, 10);
      seg(1'b1, 3); seg(1'b0, 10);
      chk("bounce_level", btn_level, 0);
      chk("bounce_count", press_count, exp_count);
      // bounce on release
      seg(1'b1, 10); seg(1'b0, 2); seg(1'b1, 3); seg(1'b0, 10);
      chk("release_count", press_count, exp_count);
      // reset mid-count and mid-high discards progress
      seg(1'b1, 3);
      do_reset(2);
      seg(1'b0, 10);
      seg(1'b1, 8);
      do_reset(2);
      seg(1'b0, 10);
      chk("post_rst_count", press_count, 0);
`ifdef DEBOUNCE_LONG_PRESS_EN
      lp0 = lp_cnt;
      seg(1'b1, 30);
      chk("lp_once", lp_cnt - lp0, 1);
      chk("lp_delay", lp_edge - last_rise_edge, LONG_CYCLES - 1);
      seg(1'b0, 10);
      lp0 = lp_cnt;
      seg(1'b1, 5); seg(1'b0, 10);
      chk("lp_short", lp_cnt - lp0, 0);
      lp0 = lp_cnt;
      seg(1'b1, 25); seg(1'b0, 2); seg(1'b1, 30); seg(1'b0, 10);
      chk("lp_no_rearm", lp_cnt - lp0, 1);
      lp0 = lp_cnt;
      seg(1'b1, 12);
      do_reset(2);
      seg(1'b0, 20);
      chk("lp_rst", lp_cnt - lp0, 0);
`endif
      // wrap of press_count over 2^PCOUNT_W presses
      do_reset(2);
      seg(1'b0, 5);
      rise_seen = 0;
      repeat (1 << PCOUNT_W) begin
         seg(1'b1, 6);
         seg(1'b0, 6);
      end
      seg(1'b0, 10);
      chk("wrap_rises", rise_seen, 1 << PCOUNT_W);
      chk("wrap_count", press_count, 0);
      chk("wrap_level", btn_level, 0);
      chk("queue_drained", q.size(), 0);
`ifndef DEBOUNCE_LONG_PRESS_EN
      chk("long_tied_low", lp_cnt, 0);
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
